serial_bit_feeder: RTL and testbench
====================================

// Module: serial_bit_feeder
// PURPOSE
//  Parallel-in/serial-out stage directly upstream of the 10101 sequence detector.
//  Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per
//  paced slot on xout, with xout_valid qualifying each bit.
//  xout drives the detector's xin; tie bit_en=1 so xin gets one new bit per clk.
// PARAMETERS
//  WIDTH      8  data bits per word (2..32)
//  MSB_FIRST  1  1: din[WIDTH-1] is sent first; 0: din[0] is sent first
//  IDLE_BIT   0  level driven on xout in reset and whenever no bit is being presented
// PORTS
//  clk         in   1      clock, all state updates on posedge
//  rst         in   1      asynchronous, active-low reset
//  din         in   WIDTH  parallel word to serialize
//  din_valid   in   1      din holds a word
//  din_ready   out  1      combinational; word accepted on posedge when valid&&ready
//  bit_en      in   1      pacing strobe; one serial slot per cycle with bit_en=1
//  xout        out  1      registered serial data to detector xin
//  xout_valid  out  1      registered; high for exactly the cycle after each emitting edge
//  busy        out  1      registered; high while in SHIFT or PAR
//  words_sent  out  8      registered count of fully emitted words, wraps 255->0
// BEHAVIOUR
//  Reset (rst=0, any time, async): state=IDLE, xout=IDLE_BIT, xout_valid=0, busy=0,
//   words_sent=0, shift reg/bit counter cleared; a word in flight is discarded.
//  States: IDLE, SHIFT, PAR (PAR exists only with PARITY_EN).
//  IDLE: din_ready=1. On accept: shreg<=din, bitcnt<=0, state->SHIFT, busy<=1.
//   xout holds last value; xout_valid=0.
//  SHIFT, edge with bit_en=1: xout<=head bit of shreg (MSB or LSB per MSB_FIRST),
//   xout_valid<=1, shreg shifts toward head, bitcnt<=bitcnt+1.
//  SHIFT, edge with bit_en=0: xout holds, xout_valid<=0, nothing advances.
//  Last data bit (bitcnt==WIDTH-1, bit_en=1): without parity -> words_sent+1 and
//   IDLE, or reload directly if a word is accepted on the same edge; with parity -> PAR.
//  din_ready = IDLE || (SHIFT && bitcnt==WIDTH-1 && bit_en && no parity)
//   || (PAR && bit_en). Back-to-back words give contiguous bits, no idle slot.
//  Latency: word accepted at edge N, bit_en=1 -> first bit on xout after edge N+1;
//   word fully on line after edge N+WIDTH (N+WIDTH+1 with parity).
//  xout returns to IDLE_BIT on the first edge in IDLE with no accept (not while paced).
//  din is sampled only on accept; changes to din while busy are ignored.
//  bitcnt width = clog2(WIDTH)+1; no overflow possible.
// CONFIGURATION
//  Macro SERIAL_PARITY_EN:
//   defined: after the WIDTH data bits, PAR emits one even-parity bit (^data) on the
//    next bit_en slot; words_sent increments on the parity-bit edge.
//   undefined: no PAR state and no parity bit; words_sent increments on last data bit.
// TESTING
//  1 rst=0 mid-run -> xout=0, xout_valid=0, busy=0, din_ready=1, words_sent=0.
//  2 din=8'h15, bit_en=1 -> xout 0,0,0,1,0,1,0,1 on 8 consecutive cycles, valid high
//    for 8 cycles; attached detector out=1 one cycle after the 8th bit.
//  3 din=8'hA5, bit_en toggling 1/0 -> xout_valid pulses on alternate cycles, xout
//    holds between them; 8 valid bits 1,0,1,0,0,1,0,1; words_sent=1.
//  4 8'hA5 then 8'h3C with din_valid held, bit_en=1 -> 16 contiguous valid bits, no
//    gap; din_ready high on the last-bit cycle only; words_sent=2.
//  5 rst pulsed after the 3rd bit of 8'hFF -> IDLE, words_sent=0; next word 8'h81
//    is emitted from bit 7 with no leftover bits.
//  6 SERIAL_PARITY_EN, din=8'h07 -> 9th bit 1; din=8'h03 -> 9th bit 0.

Source files
------------

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-in/serial-out feeder for the 10101 sequence detector.
// Define SERIAL_PARITY_EN to append an even-parity bit after each word's data bits.
module serial_bit_feeder #(
  parameter int   WIDTH     = 8,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             bit_en,
  output logic             xout,
  output logic             xout_valid,
  output logic             busy,
  output logic [7:0]       words_sent
);

  localparam int               CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

`ifdef SERIAL_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bitcnt;
  logic             last_slot;
  logic             accept;
`ifdef SERIAL_PARITY_EN
  logic             par_acc;
`endif

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  // Ready is opened on the final slot of a word so back-to-back words leave no gap.
  always_comb begin
    last_slot = (state == SHIFT) && (bitcnt == LAST) && bit_en;
`ifdef SERIAL_PARITY_EN
    din_ready = (state == IDLE) || ((state == PAR) && bit_en);
`else
    din_ready = (state == IDLE) || last_slot;
`endif
    accept = din_valid && din_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      xout       <= IDLE_BIT;
      xout_valid <= 1'b0;
      busy       <= 1'b0;
      words_sent <= 8'd0;
`ifdef SERIAL_PARITY_EN
      par_acc    <= 1'b0;
`endif
    end else begin
      xout_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shreg  <= din;
            bitcnt <= '0;
            state  <= SHIFT;
            busy   <= 1'b1;
`ifdef SERIAL_PARITY_EN
            par_acc <= 1'b0;
`endif
          end else begin
            xout <= IDLE_BIT;
          end
        end
        SHIFT: begin
          if (bit_en) begin
            xout       <= head_bit(shreg);
            xout_valid <= 1'b1;
            shreg      <= advance(shreg);
            bitcnt     <= bitcnt + 1'b1;
`ifdef SERIAL_PARITY_EN
            par_acc    <= par_acc ^ head_bit(shreg);
            if (last_slot) state <= PAR;
`else
            if (last_slot) begin
              words_sent <= words_sent + 1'b1;
              if (accept) begin
                shreg  <= din;
                bitcnt <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
`endif
          end
        end
`ifdef SERIAL_PARITY_EN
        PAR: begin
          if (bit_en) begin
            // par_acc already holds the XOR of every data bit of this word.
            xout       <= par_acc;
            xout_valid <= 1'b1;
            words_sent <= words_sent + 1'b1;
            if (accept) begin
              shreg   <= din;
              bitcnt  <= '0;
              par_acc <= 1'b0;
              state   <= SHIFT;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder with a small 10101 detector model on xout.
module tb_serial_bit_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       bit_en;
  logic       xout;
  logic       xout_valid;
  logic       busy;
  logic [7:0] words_sent;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] det_hist;
  logic       det_out;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .bit_en    (bit_en),
    .xout      (xout),
    .xout_valid(xout_valid),
    .busy      (busy),
    .words_sent(words_sent)
  );

  // Registered 10101 detector fed by xout, as the downstream block would be.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      det_hist <= 5'd0;
      det_out  <= 1'b0;
    end else begin
      det_out <= xout_valid && ({det_hist[3:0], xout} == 5'b10101);
      if (xout_valid) det_hist <= {det_hist[3:0], xout};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  logic [7:0]  w;
  logic [15:0] stream;
  logic        held;

  initial begin
    rst = 1'b0; din = 8'h00; din_valid = 1'b0; bit_en = 1'b0;
    repeat (2) tick();
    check("rst_xout", xout, 0);
    check("rst_xout_valid", xout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_din_ready", din_ready, 1);
    check("rst_words_sent", words_sent, 0);
    rst = 1'b1;
    tick();

    // 8'h15 at full rate; detector fires one cycle after the last bit
    w = 8'h15; din = w; din_valid = 1'b1; bit_en = 1'b1;
    check("t2_ready_idle", din_ready, 1);
    tick();
    din_valid = 1'b0;
    check("t2_busy", busy, 1);
    check("t2_valid_pre", xout_valid, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t2_valid", xout_valid, 1);
      check("t2_bit", xout, w[7-i]);
    end
    check("t2_words", words_sent, 1);
    check("t2_busy_done", busy, 0);
    tick();
    check("t2_detect", det_out, 1);
    check("t2_valid_after", xout_valid, 0);
    check("t2_idle_bit", xout, 0);

    // 8'hA5 with bit_en alternating; din changes while busy are ignored
    do_reset();
    w = 8'hA5; din = w; din_valid = 1'b1; bit_en = 1'b0;
    tick();
    din_valid = 1'b0; din = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_en = 1'b1;
      tick();
      check("t3_valid_on", xout_valid, 1);
      check("t3_bit", xout, w[7-i]);
      held = xout;
      din = ~din;
      bit_en = 1'b0;
      tick();
      check("t3_valid_off", xout_valid, 0);
      if (i < 7) check("t3_hold", xout, held);
    end
    check("t3_words", words_sent, 1);
    check("t3_idle_bit", xout, 0);

    // 8'hA5 then 8'h3C back to back
    do_reset();
    stream = 16'hA53C;
    din = 8'hA5; din_valid = 1'b1; bit_en = 1'b1;
    tick();
    din = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      check("t4_ready", din_ready, (i == 7 || i == 15) ? 1 : 0);
      tick();
      if (i == 7) din_valid = 1'b0;
      check("t4_valid", xout_valid, 1);
      check("t4_bit", xout, stream[15-i]);
    end
    check("t4_words", words_sent, 2);
    check("t4_busy_done", busy, 0);

    // Asynchronous reset mid-word, then a clean word
    din = 8'hFF; din_valid = 1'b1; bit_en = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_ff_bit", xout, 1);
    end
    rst = 1'b0;
    #1;
    check("t1_xout", xout, 0);
    check("t1_xout_valid", xout_valid, 0);
    check("t1_busy", busy, 0);
    check("t1_din_ready", din_ready, 1);
    check("t1_words_sent", words_sent, 0);
    tick();
    rst = 1'b1;
    w = 8'h81; din = w; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t5_valid", xout_valid, 1);
      check("t5_bit", xout, w[7-i]);
    end
    check("t5_words", words_sent, 1);

`ifdef SERIAL_PARITY_EN
    // Even parity trailer: 8'h07 -> 1, 8'h03 -> 0
    do_reset();
    w = 8'h07; din = w; din_valid = 1'b1; bit_en = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t6a_bit", xout, w[7-i]);
    end
    check("t6a_words_pre", words_sent, 0);
    check("t6a_ready_par", din_ready, 1);
    tick();
    check("t6a_par_valid", xout_valid, 1);
    check("t6a_parity", xout, 1);
    check("t6a_words", words_sent, 1);
    w = 8'h03; din = w; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t6b_bit", xout, w[7-i]);
    end
    tick();
    check("t6b_par_valid", xout_valid, 1);
    check("t6b_parity", xout, 0);
    check("t6b_words", words_sent, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
